// File: rtl/candy_pkg.sv
// Shared definitions for the candy vending datapath: sequencer states, item codes, timer limit selects.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package candy_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_PULSE = 3'd2,
        S_WAIT  = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5,
        S_FAULT = 3'd6
    } state_t;

    // Item / fault codes; NONE doubles as "no fault".
    localparam logic [1:0] ITEM_NONE  = 2'b00;
    localparam logic [1:0] ITEM_CANDY = 2'b01;
    localparam logic [1:0] ITEM_OBEG  = 2'b10;
    localparam logic [1:0] ITEM_BEG   = 2'b11;

    // Limit selects for the shared dispense timer.
    localparam logic [1:0] TSEL_PULSE = 2'd0;
    localparam logic [1:0] TSEL_GAP   = 2'd1;
    localparam logic [1:0] TSEL_WAIT  = 2'd2;

    // Coin values shared with the vending FSM.
    localparam int COIN_BEG_VALUE  = 1;
    localparam int COIN_OBEG_VALUE = 5;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dispense_timer.sv
// Shared up-counter; hit flags the last cycle of the selected limit (pulse, gap or sensor timeout).
// Latency: hit is combinational from the count; the count itself is registered.
// Backpressure: none; clr restarts the count at 0 on the next edge.
// Ports: clk, reset (async active-low), clr (restart), sel (limit select), hit (count == limit-1).
module dispense_timer import candy_pkg::*; #(
    parameter int PULSE_CYCLES   = 8,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int W              = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic [1:0] sel,
    output logic       hit
);

    logic [W-1:0] cnt;
    logic [W-1:0] limit;

    always_comb begin
        limit = W'(TIMEOUT_CYCLES - 1);
        case (sel)
            TSEL_PULSE: limit = W'(PULSE_CYCLES - 1);
            TSEL_GAP:   limit = W'(GAP_CYCLES - 1);
            default:    limit = W'(TIMEOUT_CYCLES - 1);
        endcase
    end

    assign hit = (cnt == limit);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dispense_sequencer.sv
// Pays out one dispense job (candy, obeg, 0-7 beg) one actuator pulse at a time with gaps between items.
// Latency: first actuator rises 2 cycles after req; each item costs PULSE+GAP+1 cycles (+ sensor wait).
// Backpressure: req is only sampled in IDLE; requests while busy are dropped, never queued.
// Build option: DISPENSE_SENSE_EN enables drop-sensor confirmation, timeout FAULT and fault_clr.
// Ports: clk, reset (async active-low), req/req_candy/req_beg/req_obeg (job), item_sense, fault_clr,
//        busy, done, fault, fault_code, candy_act, obeg_act, beg_act (all outputs registered).
module dispense_sequencer import candy_pkg::*; #(
    parameter int PULSE_CYCLES   = 8,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       req_candy,
    input  logic [2:0] req_beg,
    input  logic       req_obeg,
    input  logic       item_sense,
    input  logic       fault_clr,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic       candy_act,
    output logic       obeg_act,
    output logic       beg_act
);

    localparam int TW = $clog2(max3(PULSE_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES) + 1);

    state_t     state;
    logic       job_candy;
    logic       job_obeg;
    logic [2:0] job_beg;
    logic [1:0] cur_item;
    logic       tmr_clr;
    logic       tmr_hit;
    logic [1:0] tmr_sel;

    always_comb begin
        tmr_sel = TSEL_PULSE;
        if (state == S_GAP) begin
            tmr_sel = TSEL_GAP;
        end else if (state == S_WAIT) begin
            tmr_sel = TSEL_WAIT;
        end
    end

    // The timer idles at 0 outside timed states and restarts whenever a timed
    // state ends, so it always reads 0 on entry to the next timed state.
`ifdef DISPENSE_SENSE_EN
    assign tmr_clr = !(state inside {S_PULSE, S_WAIT, S_GAP}) || tmr_hit ||
                     ((state == S_WAIT) && item_sense);
`else
    assign tmr_clr = !(state inside {S_PULSE, S_GAP}) || tmr_hit;
    assign fault      = 1'b0;
    assign fault_code = ITEM_NONE;
    wire unused_sense = &{1'b0, item_sense, fault_clr, cur_item};
`endif

    dispense_timer #(
        .PULSE_CYCLES  (PULSE_CYCLES),
        .GAP_CYCLES    (GAP_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .W             (TW)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .clr  (tmr_clr),
        .sel  (tmr_sel),
        .hit  (tmr_hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            job_candy  <= 1'b0;
            job_obeg   <= 1'b0;
            job_beg    <= '0;
            cur_item   <= ITEM_NONE;
            busy       <= 1'b0;
            done       <= 1'b0;
            candy_act  <= 1'b0;
            obeg_act   <= 1'b0;
            beg_act    <= 1'b0;
`ifdef DISPENSE_SENSE_EN
            fault      <= 1'b0;
            fault_code <= ITEM_NONE;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (req) begin
                        job_candy <= req_candy;
                        job_obeg  <= req_obeg;
                        job_beg   <= req_beg;
                        busy      <= 1'b1;
                        state     <= S_LOAD;
                    end
                end
                // Fixed priority: candy, obeg, then beg coins one at a time.
                S_LOAD: begin
                    if (job_candy) begin
                        job_candy <= 1'b0;
                        cur_item  <= ITEM_CANDY;
                        candy_act <= 1'b1;
                        state     <= S_PULSE;
                    end else if (job_obeg) begin
                        job_obeg  <= 1'b0;
                        cur_item  <= ITEM_OBEG;
                        obeg_act  <= 1'b1;
                        state     <= S_PULSE;
                    end else if (job_beg != 3'd0) begin
                        job_beg   <= job_beg - 3'd1;
                        cur_item  <= ITEM_BEG;
                        beg_act   <= 1'b1;
                        state     <= S_PULSE;
                    end else begin
                        cur_item  <= ITEM_NONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_PULSE: begin
                    if (tmr_hit) begin
                        candy_act <= 1'b0;
                        obeg_act  <= 1'b0;
                        beg_act   <= 1'b0;
`ifdef DISPENSE_SENSE_EN
                        state     <= S_WAIT;
`else
                        state     <= S_GAP;
`endif
                    end
                end
`ifdef DISPENSE_SENSE_EN
                // Sensor is checked first so a drop on the timeout cycle still counts.
                S_WAIT: begin
                    if (item_sense) begin
                        state <= S_GAP;
                    end else if (tmr_hit) begin
                        fault      <= 1'b1;
                        fault_code <= cur_item;
                        job_candy  <= 1'b0;
                        job_obeg   <= 1'b0;
                        job_beg    <= '0;
                        state      <= S_FAULT;
                    end
                end
                S_FAULT: begin
                    if (fault_clr) begin
                        fault      <= 1'b0;
                        fault_code <= ITEM_NONE;
                        busy       <= 1'b0;
                        cur_item   <= ITEM_NONE;
                        job_candy  <= 1'b0;
                        job_obeg   <= 1'b0;
                        job_beg    <= '0;
                        state      <= S_IDLE;
                    end
                end
`endif
                S_GAP: begin
                    if (tmr_hit) begin
                        state <= S_LOAD;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dispense_sequencer.md
# dispense_sequencer

Sequences the physical payout after a vend decision. It accepts one dispense job at a time: optional candy, 0–7 beg coins and an optional obeg coin. It drives the three actuators one item at a time, with a fixed pulse width and an inter-item gap, and confirms each drop on a shared item sensor. It sits between the vending FSM (`candy`, `change_beg`, `change_obeg`) and the mechanism drivers.

## Interface
Parameters:
- `PULSE_CYCLES`, 8 — actuator on-time per item, in cycles (≥1)
- `GAP_CYCLES`, 2 — idle cycles between items (≥1)
- `TIMEOUT_CYCLES`, 255 — maximum wait for the item sensor per item (≥1)

Ports:
- `clk`  in  1  — single clock, all logic on its rising edge
- `reset`  in  1  — asynchronous, active-low; low forces all state and outputs to reset values immediately
- `req`  in  1  — job strobe; sampled only in IDLE
- `req_candy`  in  1  — job includes one candy
- `req_beg`  in  3  — number of beg coins to pay
- `req_obeg`  in  1  — job includes one obeg coin
- `item_sense`  in  1  — mechanism drop sensor, synchronous to `clk`
- `fault_clr`  in  1  — leaves FAULT
- `busy`  out  1  — job accepted and not yet finished, or in FAULT
- `done`  out  1  — one-cycle pulse when a job finishes normally
- `fault`  out  1  — high for as long as the block is in FAULT
- `fault_code`  out  2  — item that timed out: 01 candy, 10 obeg, 11 beg; 00 when not in FAULT
- `candy_act`, `obeg_act`, `beg_act`  out  1 each — actuator drives, registered

## Operation
- Reset values: all outputs 0; state IDLE; job registers 0.
- States: IDLE, LOAD, PULSE, WAIT_SENSE, GAP, DONE, FAULT.
- IDLE:
  - `req`=1 latches `req_candy`, `req_beg`, `req_obeg` into job registers and moves to LOAD.
  - `req` outside IDLE is ignored, with no queueing.
- LOAD:
  - Selects the next item in fixed priority: candy, then obeg, then beg (the beg count decrements once per beg item).
  - An item is selected → PULSE; no items remain → DONE.
- PULSE:
  - Exactly one actuator, the selected one, is high for `PULSE_CYCLES` cycles.
  - Then → WAIT_SENSE.
- WAIT_SENSE:
  - `item_sense`=1 → GAP.
  - Otherwise the timer increments.
  - After `TIMEOUT_CYCLES` cycles with sensor low → FAULT.
  - If the sensor goes high on the same cycle as the timeout, the sensor wins.
- GAP: `GAP_CYCLES` cycles with no actuator high, then → LOAD.
- DONE: `done`=1 and `busy`=0 for one cycle, then → IDLE.
- FAULT:
  - All actuators low; `fault`=1; `busy`=1; `fault_code` set; remaining job discarded.
  - `fault_clr`=1 → IDLE, and the job registers are cleared.
- Empty job (all request fields 0): IDLE → LOAD → DONE, no actuator activity.
- `req_beg` up to 7 is honoured. The vending FSM issues at most 5.
- At most one actuator is ever high.
- Reset asserted mid-job drops all actuators asynchronously and abandons the job. Nothing resumes after reset releases.

## Timing
- Cycle 0: `req` sampled in IDLE.
- Cycle 1: LOAD, `busy`=1.
- Cycle 2: first actuator high, for cycles 2 through 1+`PULSE_CYCLES`.
- Per item, the minimum is PULSE_CYCLES + 1 (one WAIT_SENSE cycle with the sensor already high) + GAP_CYCLES + 1 (LOAD).
- Timer width: `$clog2(max(PULSE_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES)+1)`. The timer reloads to 0 on every state entry.
- `fault` rises the cycle after the final timed-out WAIT_SENSE cycle.
- `done` is a single-cycle pulse.

## Configuration
- `DISPENSE_SENSE_EN` defined:
  - Sensor feedback and timeout are as above.
- `DISPENSE_SENSE_EN` undefined:
  - `item_sense` and `fault_clr` are ignored.
  - WAIT_SENSE and FAULT are compiled out; PULSE goes directly to GAP.
  - `fault` and `fault_code` are tied to 0.

## Structure
- Shared package `candy_pkg`:
  - State enum.
  - Item/fault code constants (NONE=00, CANDY=01, OBEG=10, BEG=11).
  - Coin-value constants shared with the vending FSM.
- Sub-module `dispense_timer`: a loadable up-counter with a `hit` compare against a selected limit (pulse, gap or timeout). It is instantiated once and shared by all states.

## Test plan
- Candy=1, beg=2, obeg=1; sensor pulses 1 cycle after each pulse ends → actuator order candy, obeg, beg, beg; each high for exactly 8 cycles; `done` once; `busy` falls with `done`.
- Empty job → `done` at cycle 2; no actuator ever high.
- beg=3 with the sensor stuck low on the 2nd beg (sense build) → FAULT after 255 WAIT cycles; `fault_code`=11; actuators low. `fault_clr` → IDLE; a new `req` is accepted.
- `req` pulsed while `busy` → ignored; job registers unchanged; item count unchanged.
- Reset driven low during PULSE → `beg_act`/`candy_act` drop within the same cycle. After release: IDLE, all outputs 0.
- Build without `DISPENSE_SENSE_EN`, beg=7 → seven beg pulses spaced 8+2+1 cycles apart; `fault` stays 0.
